// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Central stall/flush generator for the six pipeline registers
//   (pc, if_id, id1_id2, id2_ex, ex_mem, mem_wb). A register clears on
//   (flush & !stall) or exception_flush, holds on stall, and loads otherwise.
//   This block resolves load-use hazards, the multi-cycle divide, I/D memory
//   wait, deferred branch squash and exception squash.
//
//   Optional feature: define PIPE_HAZARD_PERF_EN to add three 32-bit
//   stall-cause counters (perf_lu_cnt, perf_div_cnt, perf_mem_cnt).
//
// Parameters
//   DIV_LAT  total EX stall cycles for one div/divu (>= 2)
//   CNT_W    width of the divide countdown (2**CNT_W > DIV_LAT)
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   id2_rs/id2_rt(+_ren)     source registers of the ID2 instruction
//   ex_is_load, ex_w_reg_dst load in EX and its destination
//   ex_div_start             valid div/divu in EX (held while EX is stalled)
//   ex_branch_taken          branch/jump in EX redirects; delay slot is in ID2
//   imem_stall_req           fetch not returned
//   dmem_stall_req           MEM access not complete
//   mem_exception            exception/eret committed in MEM
//   *_stall, *_flush         per-register hold / clear controls
//   exception_flush          squash all stage registers
//   div_busy                 divide counting down (stalling in DIV_BUSY)
//   dbg_state                current FSM state (RUN/DIV_BUSY/EXC_HOLD)
//
// Handshake: there is no valid/ready pair here; each *_stall/*_flush is a
//   level that applies to the register's update on the next rising clk.
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int DIV_LAT = 36,
   parameter int CNT_W   = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id2_rs,
   input  logic [4:0] id2_rt,
   input  logic       id2_rs_ren,
   input  logic       id2_rt_ren,
   input  logic       ex_is_load,
   input  logic [4:0] ex_w_reg_dst,
   input  logic       ex_div_start,
   input  logic       ex_branch_taken,
   input  logic       imem_stall_req,
   input  logic       dmem_stall_req,
   input  logic       mem_exception,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       id1_id2_stall,
   output logic       id2_ex_stall,
   output logic       ex_mem_stall,
   output logic       mem_wb_stall,
   output logic       if_id_flush,
   output logic       id1_id2_flush,
   output logic       id2_ex_flush,
   output logic       ex_mem_flush,
   output logic       mem_wb_flush,
   output logic       exception_flush,
   output logic       div_busy,
`ifdef PIPE_HAZARD_PERF_EN
   output logic [31:0] perf_lu_cnt,
   output logic [31:0] perf_div_cnt,
   output logic [31:0] perf_mem_cnt,
`endif
   output logic [1:0] dbg_state
);

   localparam logic [1:0] RUN      = 2'd0;
   localparam logic [1:0] DIV_BUSY = 2'd1;
   localparam logic [1:0] EXC_HOLD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             redir_q, redir_d;

   logic div_act, lu_act, live;
   logic s_ex_mem, s_id2_ex, s_id1_id2, s_if_id;
   logic br_accept, redir_want, br_flush;

   // Hazard detection. Register 0 is hardwired, so it never creates a hazard.
   assign lu_act = ex_is_load && (ex_w_reg_dst != 5'd0) &&
                   ((id2_rs_ren && (id2_rs == ex_w_reg_dst)) ||
                    (id2_rt_ren && (id2_rt == ex_w_reg_dst)));

   // The zero-count cycle in DIV_BUSY is the drain cycle: the divide result
   // leaves EX without stalling and ex_div_start is not re-sampled.
   assign div_act = ((state_q == RUN) && ex_div_start) ||
                    ((state_q == DIV_BUSY) && (cnt_q != '0));

   // Stalls accumulate from the back of the pipe forward.
   assign s_ex_mem  = dmem_stall_req;
   assign s_id2_ex  = s_ex_mem  || div_act;
   assign s_id1_id2 = s_id2_ex  || lu_act;
   assign s_if_id   = s_id1_id2 || imem_stall_req;

   // A taken branch only counts once EX actually advances. Its squash of the
   // IF/ID1 instructions waits until both front registers are free to clear.
   assign br_accept  = ex_branch_taken && !s_ex_mem;
   assign redir_want = redir_q || br_accept;
   assign br_flush   = redir_want && !s_if_id && !s_id1_id2;

   // Everything is quiet while in reset or while an exception squashes.
   assign live = rst && !mem_exception;

   assign pc_stall      = live && s_if_id;
   assign if_id_stall   = live && s_if_id;
   assign id1_id2_stall = live && s_id1_id2;
   assign id2_ex_stall  = live && s_id2_ex;
   assign ex_mem_stall  = live && s_ex_mem;
   assign mem_wb_stall  = 1'b0;

   assign if_id_flush   = live && ((state_q == EXC_HOLD) || br_flush) && !s_if_id;
   assign id1_id2_flush = live && (imem_stall_req || br_flush) && !s_id1_id2;
   assign id2_ex_flush  = live && lu_act && !s_id2_ex;
   assign ex_mem_flush  = live && div_act && !s_ex_mem;
   assign mem_wb_flush  = live && dmem_stall_req;

   assign exception_flush = rst && mem_exception;
   assign div_busy        = rst && (state_q == DIV_BUSY) && (cnt_q != '0);
   assign dbg_state       = state_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      redir_d = redir_q;
      if (mem_exception) begin
         state_d = EXC_HOLD;
         cnt_d   = '0;
         redir_d = 1'b0;
      end else begin
         redir_d = redir_want && (s_if_id || s_id1_id2);
         // A D-memory wait freezes the divide sequence, including the drain
         // cycle, so the divide in EX is neither restarted nor lost.
         case (state_q)
            EXC_HOLD: state_d = RUN;
            RUN: begin
               if (ex_div_start && !dmem_stall_req) begin
                  state_d = DIV_BUSY;
                  cnt_d   = CNT_W'(DIV_LAT - 1);
               end
            end
            DIV_BUSY: begin
               if (!dmem_stall_req) begin
                  if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                  else             state_d = RUN;
               end
            end
            default: state_d = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= RUN;
         cnt_q   <= '0;
         redir_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         redir_q <= redir_d;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   // Only the winning stall cause of a cycle is counted (dmem > div > load-use).
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         perf_lu_cnt  <= '0;
         perf_div_cnt <= '0;
         perf_mem_cnt <= '0;
      end else if (!mem_exception) begin
         if (dmem_stall_req)   perf_mem_cnt <= perf_mem_cnt + 32'd1;
         else if (div_act)     perf_div_cnt <= perf_div_cnt + 32'd1;
         else if (lu_act)      perf_lu_cnt  <= perf_lu_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Directed scenarios followed by randomized traffic, all compared each cycle
//   against a reference model that tracks the pipeline as "how deep the stall
//   reaches" plus divide progress in delivered stall cycles.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

   localparam int DIV_LAT = 36;

   typedef struct packed {
      logic pc_s, if_id_s, id1_id2_s, id2_ex_s, ex_mem_s, mem_wb_s;
      logic if_id_f, id1_id2_f, id2_ex_f, ex_mem_f, mem_wb_f;
      logic exc_f, busy;
   } outs_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic [4:0] id2_rs, id2_rt, ex_w_reg_dst;
   logic       id2_rs_ren, id2_rt_ren, ex_is_load, ex_div_start, ex_branch_taken;
   logic       imem_stall_req, dmem_stall_req, mem_exception;
   logic       pc_stall, if_id_stall, id1_id2_stall, id2_ex_stall, ex_mem_stall, mem_wb_stall;
   logic       if_id_flush, id1_id2_flush, id2_ex_flush, ex_mem_flush, mem_wb_flush;
   logic       exception_flush, div_busy;
   logic [1:0] dbg_state;
`ifdef PIPE_HAZARD_PERF_EN
   logic [31:0] perf_lu_cnt, perf_div_cnt, perf_mem_cnt;
`endif

   pipe_hazard_ctrl #(.DIV_LAT(DIV_LAT), .CNT_W(6)) dut (
      .clk(clk), .rst(rst),
      .id2_rs(id2_rs), .id2_rt(id2_rt), .id2_rs_ren(id2_rs_ren), .id2_rt_ren(id2_rt_ren),
      .ex_is_load(ex_is_load), .ex_w_reg_dst(ex_w_reg_dst), .ex_div_start(ex_div_start),
      .ex_branch_taken(ex_branch_taken), .imem_stall_req(imem_stall_req),
      .dmem_stall_req(dmem_stall_req), .mem_exception(mem_exception),
      .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id1_id2_stall(id1_id2_stall),
      .id2_ex_stall(id2_ex_stall), .ex_mem_stall(ex_mem_stall), .mem_wb_stall(mem_wb_stall),
      .if_id_flush(if_id_flush), .id1_id2_flush(id1_id2_flush), .id2_ex_flush(id2_ex_flush),
      .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
      .exception_flush(exception_flush), .div_busy(div_busy),
`ifdef PIPE_HAZARD_PERF_EN
      .perf_lu_cnt(perf_lu_cnt), .perf_div_cnt(perf_div_cnt), .perf_mem_cnt(perf_mem_cnt),
`endif
      .dbg_state(dbg_state)
   );

   // ---------------- scoreboard counters ----------------
   int n_assert = 0;
   int n_fail   = 0;
   outs_t last_obs;
   int t_id2_stall, t_exm_flush, t_busy, t_mwb_flush;

   // ---------------- reference model ----------------
   bit m_in_div;     // a divide has been accepted and not yet drained
   int m_div_done;   // stall cycles delivered so far for that divide
   bit m_exc_hold;   // cycle right after an exception
   bit m_redir;      // branch squash owed to the front end
   int c_depth;      // how many leading registers are held this cycle
   bit c_accept, c_dv;

   task automatic model_reset();
      m_in_div = 1'b0; m_div_done = 0; m_exc_hold = 1'b0; m_redir = 1'b0;
   endtask

   task automatic model_eval(output outs_t o);
      bit lu, brf;
      o = '0; c_depth = 0; c_accept = 1'b0; c_dv = 1'b0;
      if (!rst) return;
      o.busy = m_in_div && (m_div_done < DIV_LAT);
      if (mem_exception) begin o.exc_f = 1'b1; return; end
      lu = ex_is_load && (ex_w_reg_dst != 0) &&
           ((id2_rs_ren && id2_rs == ex_w_reg_dst) || (id2_rt_ren && id2_rt == ex_w_reg_dst));
      c_dv = m_in_div ? (m_div_done < DIV_LAT) : (!m_exc_hold && ex_div_start);
      if (imem_stall_req) c_depth = 2;
      if (lu)             c_depth = 3;
      if (c_dv)           c_depth = 4;
      if (dmem_stall_req) c_depth = 5;
      o.pc_s = c_depth > 0; o.if_id_s = c_depth > 1; o.id1_id2_s = c_depth > 2;
      o.id2_ex_s = c_depth > 3; o.ex_mem_s = c_depth > 4; o.mem_wb_s = 1'b0;
      c_accept = ex_branch_taken && c_depth < 5;
      brf = (m_redir || c_accept) && c_depth < 2;
      o.if_id_f   = (m_exc_hold || brf) && !o.if_id_s;
      o.id1_id2_f = (imem_stall_req || brf) && !o.id1_id2_s;
      o.id2_ex_f  = lu && !o.id2_ex_s;
      o.ex_mem_f  = c_dv && !o.ex_mem_s;
      o.mem_wb_f  = dmem_stall_req;
   endtask

   task automatic model_update();
      if (!rst) begin model_reset(); return; end
      if (mem_exception) begin
         m_in_div = 1'b0; m_div_done = 0; m_exc_hold = 1'b1; m_redir = 1'b0;
         return;
      end
      m_redir    = (m_redir || c_accept) && c_depth > 1;
      m_exc_hold = 1'b0;
      if (!dmem_stall_req) begin
         if (m_in_div) begin
            if (m_div_done >= DIV_LAT) begin m_in_div = 1'b0; m_div_done = 0; end
            else m_div_done++;
         end else if (c_dv) begin
            m_in_div = 1'b1; m_div_done = 1;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      id2_rs = 0; id2_rt = 0; id2_rs_ren = 0; id2_rt_ren = 0;
      ex_is_load = 0; ex_w_reg_dst = 0; ex_div_start = 0; ex_branch_taken = 0;
      imem_stall_req = 0; dmem_stall_req = 0; mem_exception = 0;
   endtask

   // Called right after a falling edge with inputs applied: check the
   // combinational outputs, advance the model, wait for the next falling edge.
   task automatic step(input string tag);
      outs_t exp_o;
      #1;
      last_obs = {pc_stall, if_id_stall, id1_id2_stall, id2_ex_stall, ex_mem_stall, mem_wb_stall,
                  if_id_flush, id1_id2_flush, id2_ex_flush, ex_mem_flush, mem_wb_flush,
                  exception_flush, div_busy};
      t_id2_stall += int'(id2_ex_stall);
      t_exm_flush += int'(ex_mem_flush);
      t_busy      += int'(div_busy);
      t_mwb_flush += int'(mem_wb_flush);
      model_eval(exp_o);
      n_assert++;
      assert (last_obs === exp_o) else begin
         n_fail++;
         $error("FAIL %s obs=%b exp=%b", tag, last_obs, exp_o);
      end
      model_update();
      @(negedge clk);
   endtask

   task automatic check_val(input string tag, input int obs, input int exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp_v);
      end
   endtask

   task automatic clear_tally();
      t_id2_stall = 0; t_exm_flush = 0; t_busy = 0; t_mwb_flush = 0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- directed then random sequence ----------------
   initial begin
      clear_inputs();
      model_reset();
      clear_tally();
      @(negedge clk);

      // Reset: all outputs 0 even with requests present.
      mem_exception = 1; dmem_stall_req = 1; ex_div_start = 1;
      step("reset_quiet");
      check_val("reset_all_zero", int'(last_obs), 0);
      clear_inputs();
      rst = 1'b1;
      step("idle_run");
      check_val("idle_all_zero", int'(last_obs), 0);

      // Load-use on rs.
      ex_is_load = 1; ex_w_reg_dst = 5; id2_rs = 5; id2_rs_ren = 1;
      step("lu_hit");
      check_val("lu_stall_flush", int'({last_obs.pc_s, last_obs.if_id_s, last_obs.id1_id2_s,
                                        last_obs.id2_ex_s, last_obs.id2_ex_f}), 5'b11101);
      clear_inputs();
      step("lu_after");
      check_val("lu_after_clear", int'(last_obs), 0);
      // Register 0 never hazards.
      ex_is_load = 1; ex_w_reg_dst = 0; id2_rs = 0; id2_rs_ren = 1;
      step("lu_r0");
      check_val("lu_r0_none", int'(last_obs), 0);
      clear_inputs();

      // Divide alone: 36 stall cycles, 35 busy cycles.
      clear_tally();
      for (int i = 0; i < 45; i++) begin
         ex_div_start = (i < 37);
         step("div_plain");
      end
      check_val("div_id2_ex_stall_cycles", t_id2_stall, DIV_LAT);
      check_val("div_ex_mem_flush_cycles", t_exm_flush, DIV_LAT);
      check_val("div_busy_cycles", t_busy, DIV_LAT - 1);

      // Divide with a 4-cycle D-memory wait in flight.
      clear_tally();
      for (int i = 0; i < 48; i++) begin
         ex_div_start   = (i < 41);
         dmem_stall_req = (i >= 10 && i <= 13);
         step("div_dmem");
      end
      check_val("div_dmem_stall_cycles", t_id2_stall, DIV_LAT + 4);
      check_val("div_dmem_mem_wb_flush", t_mwb_flush, 4);
      clear_inputs();

      // Branch taken during load-use: squash deferred by one cycle.
      ex_is_load = 1; ex_w_reg_dst = 7; id2_rt = 7; id2_rt_ren = 1; ex_branch_taken = 1;
      step("br_lu");
      check_val("br_lu_no_flush", int'({last_obs.if_id_f, last_obs.id1_id2_f}), 0);
      clear_inputs();
      step("br_deferred");
      check_val("br_deferred_flush", int'({last_obs.if_id_f, last_obs.id1_id2_f}), 3);
      step("br_once");
      check_val("br_once_only", int'({last_obs.if_id_f, last_obs.id1_id2_f}), 0);

      // Exception during DIV_BUSY.
      ex_div_start = 1;
      for (int i = 0; i < 5; i++) step("exc_div_pre");
      mem_exception = 1;
      step("exc_div");
      check_val("exc_flush", int'(last_obs.exc_f), 1);
      check_val("exc_no_stall", int'(last_obs[12:7]), 0);
      clear_inputs();
      step("exc_hold");
      check_val("exc_hold_if_id_flush", int'(last_obs.if_id_f), 1);
      check_val("exc_hold_busy", int'(last_obs.busy), 0);
      step("exc_after");

      // Reset mid-divide.
      ex_div_start = 1;
      for (int i = 0; i < 6; i++) step("rst_div_pre");
      rst = 1'b0;
      step("rst_mid_div");
      check_val("rst_mid_div_zero", int'(last_obs), 0);
      clear_inputs();
      rst = 1'b1;
      step("rst_release");
      check_val("rst_release_idle", int'(last_obs), 0);

      // Randomized traffic.
      for (int i = 0; i < 2000; i++) begin
         mem_exception   = ($urandom_range(99) < 2);
         dmem_stall_req  = ($urandom_range(99) < 12);
         imem_stall_req  = ($urandom_range(99) < 15);
         ex_branch_taken = ($urandom_range(99) < 10);
         ex_div_start    = ($urandom_range(99) < 5);
         ex_is_load      = ($urandom_range(99) < 35);
         ex_w_reg_dst    = 5'($urandom_range(3));
         id2_rs          = 5'($urandom_range(3));
         id2_rt          = 5'($urandom_range(3));
         id2_rs_ren      = 1'($urandom_range(1));
         id2_rt_ren      = 1'($urandom_range(1));
         step("random");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
